// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multi-cycle controller.
//   mc_state_e   - FSM state codes (also driven out on the state port)
//   MC_RESET_PC  - default first fetch address after reset
//   MC_WAIT_W    - wait-counter width (covers MAX_WAIT up to 255)
//   mc_dec_t     - decode classes latched when leaving ID
package mc_pkg;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EXE  = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd7
  } mc_state_e;

  localparam logic [31:0] MC_RESET_PC = 32'h1c00_0000;
  localparam int unsigned MC_WAIT_W   = 8;

  typedef struct packed {
    logic load;
    logic store;
    logic rf_we;
  } mc_dec_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: instruction/data memory handshake between controller and memory.
//   master (controller): drives inst_req, inst_addr, data_req, data_we
//                        receives inst_ok, inst_rdata, data_ok
//   slave  (memory)    : the mirror image
interface mc_ctrl_if #(
  parameter int unsigned XLEN = 32
);

  logic            inst_req;
  logic [XLEN-1:0] inst_addr;
  logic            inst_ok;
  logic [XLEN-1:0] inst_rdata;
  logic            data_req;
  logic            data_we;
  logic            data_ok;

  modport master (
    output inst_req, inst_addr, data_req, data_we,
    input  inst_ok, inst_rdata, data_ok
  );

  modport slave (
    input  inst_req, inst_addr, data_req, data_we,
    output inst_ok, inst_rdata, data_ok
  );

endinterface

// File: rtl/mc_wait_timer.sv
// mc_wait_timer: counts cycles an outstanding request has gone without ok.
//   clk, resetn - clock, async active-low reset
//   clear       - zero the count (asserted on the cycle before a request phase starts)
//   busy        - a request is outstanding this cycle
//   ok          - the outstanding request completes this cycle
//   expired     - this is the MAX_WAIT-th waiting cycle and ok is absent
// MAX_WAIT legal range is 1..255.
module mc_wait_timer
  import mc_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic busy,
  input  logic ok,
  output logic expired
);

  localparam logic [MC_WAIT_W-1:0] LAST = MC_WAIT_W'(MAX_WAIT - 1);

  logic [MC_WAIT_W-1:0] cnt_q, cnt_d;

  // ok in the final allowed cycle wins over the timeout
  assign expired = busy & ~ok & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (busy && !ok && cnt_q != LAST) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle instruction sequencer (fetch/decode/execute/memory/writeback).
//   clk, resetn            - clock, async active-low reset
//   bus (master)           - instruction fetch and data memory handshakes
//   dec_*                  - decoded class of ir, sampled in ID
//   br_taken, br_target    - redirect applied at retire
//   pc, ir                 - current instruction address and latched word
//   rf_we, retire          - register-file write strobe, last-cycle pulse
//   state, bus_err         - FSM state code, sticky memory timeout
//
// state | meaning
// IF    | fetch request outstanding, waiting for inst_ok
// ID    | one cycle; branch-only ops retire here
// EXE   | one cycle; picks MEM, WB or retire
// MEM   | data request outstanding, waiting for data_ok
// WB    | one-cycle register write and retire
// HALT  | memory timeout; left only by reset
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(MC_RESET_PC),
  parameter int unsigned     MAX_WAIT = 16
) (
  input  logic            clk,
  input  logic            resetn,
  mc_ctrl_if.master       bus,
  input  logic            dec_load,
  input  logic            dec_store,
  input  logic            dec_br_only,
  input  logic            dec_rf_we,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] ir,
  output logic            rf_we,
  output logic            retire,
  output logic [2:0]      state,
  output logic            bus_err
);

  mc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ir_q, ir_d;
  mc_dec_t         dec_q, dec_d;
  logic            bus_err_q, bus_err_d;

  logic inst_req_o, data_req_o, data_we_o, rf_we_o, retire_o;
  logic in_if, in_mem;
  logic wait_clear, wait_busy, wait_ok, wait_expired;

  assign in_if      = (state_q == ST_IF);
  assign in_mem     = (state_q == ST_MEM);
  assign wait_busy  = in_if | in_mem;
  assign wait_ok    = (in_if & bus.inst_ok) | (in_mem & bus.data_ok);
  assign wait_clear = (state_d != state_q) && (state_d == ST_IF || state_d == ST_MEM);

  mc_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (wait_clear),
    .busy    (wait_busy),
    .ok      (wait_ok),
    .expired (wait_expired)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IF;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IF: begin
        if (bus.inst_ok)       state_d = ST_ID;
        else if (wait_expired) state_d = ST_HALT;
      end
      ST_ID:  state_d = dec_br_only ? ST_IF : ST_EXE;
      ST_EXE: begin
        if (dec_q.load || dec_q.store) state_d = ST_MEM;
        else if (dec_q.rf_we)          state_d = ST_WB;
        else                           state_d = ST_IF;
      end
      ST_MEM: begin
        if (bus.data_ok)       state_d = dec_q.store ? ST_IF : ST_WB;
        else if (wait_expired) state_d = ST_HALT;
      end
      ST_WB:   state_d = ST_IF;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
  end

  always_comb begin
    inst_req_o = 1'b0;
    data_req_o = 1'b0;
    data_we_o  = 1'b0;
    rf_we_o    = 1'b0;
    retire_o   = 1'b0;
    case (state_q)
      // state_q already sits in IF during reset; gating keeps the fetch
      // request low until resetn is released.
      ST_IF:  inst_req_o = resetn;
      ST_ID:  retire_o = dec_br_only;
      ST_EXE: retire_o = ~(dec_q.load | dec_q.store | dec_q.rf_we);
      ST_MEM: begin
        data_req_o = 1'b1;
        data_we_o  = dec_q.store;
        retire_o   = bus.data_ok & dec_q.store;
      end
      ST_WB: begin
        rf_we_o  = 1'b1;
        retire_o = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    pc_d      = pc_q;
    ir_d      = ir_q;
    dec_d     = dec_q;
    bus_err_d = bus_err_q | wait_expired;
    if (retire_o) begin
      pc_d = br_taken ? br_target : pc_q + XLEN'(4);
    end
    if (in_if && bus.inst_ok) begin
      ir_d = bus.inst_rdata;
    end
    if (state_q == ST_ID) begin
      dec_d.load  = dec_load;
      dec_d.store = dec_store;
      dec_d.rf_we = dec_rf_we;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      dec_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      dec_q     <= dec_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus.inst_req  = inst_req_o;
  assign bus.inst_addr = pc_q;
  assign bus.data_req  = data_req_o;
  assign bus.data_we   = data_we_o;
  assign pc            = pc_q;
  assign ir            = ir_q;
  assign rf_we         = rf_we_o;
  assign retire        = retire_o;
  assign state         = state_q;
  assign bus_err       = bus_err_q;

endmodule
